// File: rtl/bcd_pulse_counter_pkg.sv
// rtl/bcd_pulse_counter_pkg.sv - shared BCD limits and active-low 7-segment glyphs
package bcd_pulse_counter_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Segment order {g,f,e,d,c,b,a}; a cleared bit lights the segment.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bcd_pulse_counter_decade.sv
// rtl/bcd_pulse_counter_decade.sv - single BCD decade with combinational carry/borrow
module bcd_decade
    import bcd_pulse_counter_pkg::*;
(
    input  logic       clock,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] value,
    output logic       carry,
    output logic       borrow
);

    assign carry  = inc & ~dec & (value == BCD_MAX);
    assign borrow = dec & ~inc & (value == 4'd0);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            value <= 4'd0;
        end else if (clear) begin
            value <= 4'd0;
        end else if (inc && !dec) begin
            value <= (value >= BCD_MAX) ? 4'd0 : value + 4'd1;
        end else if (dec && !inc) begin
            // Out-of-range nibbles fold back to 9 so the decade self-recovers.
            value <= (value == 4'd0 || value > BCD_MAX) ? BCD_MAX : value - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_pulse_counter.sv
// rtl/bcd_pulse_counter.sv - BCD up/down pulse counter with muxed 7-seg scan (BCD_LZ_BLANK_EN)
module bcd_pulse_counter
    import bcd_pulse_counter_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_BITS = 18
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  up,
    input  logic                  down,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIGITS:0]        inc_chain;
    logic [DIGITS:0]        dec_chain;
    logic [SCAN_BITS-1:0]   psc;
    logic [IDX_W-1:0]       idx;
    logic                   idx_last;
    logic [3:0]             cur_digit;
    logic                   blank;
    logic [6:0]             seg_next;
    logic [DIGITS-1:0]      an_next;

    // Opposing pulses cancel at the units decade, so nothing ripples upward.
    assign inc_chain[0] = up & ~down;
    assign dec_chain[0] = down & ~up;

    for (genvar i = 0; i < DIGITS; i++) begin : g_decade
        bcd_decade u_decade (
            .clock  (clock),
            .rst_n  (rst_n),
            .clear  (clear),
            .inc    (inc_chain[i]),
            .dec    (dec_chain[i]),
            .value  (bcd[4*i +: 4]),
            .carry  (inc_chain[i+1]),
            .borrow (dec_chain[i+1])
        );
    end

    assign idx_last  = (idx == IDX_W'(DIGITS - 1));
    assign cur_digit = bcd[4*int'(idx) +: 4];
    assign an_next   = ~(DIGITS'(1) << idx);

`ifdef BCD_LZ_BLANK_EN
    // lz[i] is set when digit i and every digit above it are zero.
    logic [DIGITS-1:0] lz;
    always_comb begin
        lz = '0;
        lz[DIGITS-1] = (bcd[4*DIGITS-1 -: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            lz[i] = lz[i+1] & (bcd[4*i +: 4] == 4'd0);
        end
    end
    assign blank = (idx != '0) && lz[idx];
`else
    assign blank = 1'b0;
`endif

    assign seg_next = blank ? SEG_BLANK : seg_decode(cur_digit);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            psc  <= '0;
            idx  <= '0;
            an   <= '1;
            seg  <= SEG_BLANK;
            wrap <= 1'b0;
        end else begin
            psc  <= psc + 1'b1;
            if (&psc) begin
                idx <= idx_last ? '0 : idx + 1'b1;
            end
            an   <= an_next;
            seg  <= seg_next;
            wrap <= ~clear & (inc_chain[DIGITS] | dec_chain[DIGITS]);
        end
    end

endmodule
